csr_timer_unit: RTL

- Parametrised successor to the single-timer logic in the CSR file.
- Provides a TID register, NUM_TIMERS independent countdown timers and a free-running 64-bit stable counter for rdcntvl/rdcntvh/rdcntid.
- A configurable prescaler drives the timers.
- Sits beside the CSR file and is accessed over the same csr_we/num/mask/value write port. Its per-timer pending bits feed ESTAT.IS[11+k].

---
 rtl/csr_pkg.sv | 27 ++
 rtl/csr_timer_chan.sv | 59 +++++
 rtl/csr_timer_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared CSR address map and field positions for the timer unit.
// Channel k occupies a four-register window starting at TCFG_BASE + 4k.
package csr_pkg;

    localparam logic [13:0] CSR_TID         = 14'h40;
    localparam logic [13:0] CSR_TCFG_BASE   = 14'h41;
    localparam logic [13:0] CSR_TVAL_BASE   = 14'h42;
    localparam logic [13:0] CSR_RSV_BASE    = 14'h43;
    localparam logic [13:0] CSR_TICLR_BASE  = 14'h44;
    localparam logic [13:0] CSR_CHAN_STRIDE = 14'd4;

    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TCFG_INITVAL  = 2;
    localparam int TICLR_CLR     = 0;

    function automatic logic [13:0] chan_addr(input logic [13:0] base, input int k);
        return base + CSR_CHAN_STRIDE * 14'(k);
    endfunction

    function automatic logic [31:0] masked_merge(input logic [31:0] old,
                                                 input logic [31:0] value,
                                                 input logic [31:0] mask);
        return (mask & value) | (~mask & old);
    endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// One countdown timer channel: TCFG fields, count register and pending flag.
// A one-shot channel parks at all-ones after expiring; a periodic one reloads from INITVAL.
module csr_timer_chan
    import csr_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             tcfg_we,
    input  logic             ticlr_we,
    input  logic [CNT_W-1:0] tcfg_next,
    output logic [31:0]      tcfg,
    output logic [31:0]      tval,
    output logic             pending
);

    logic             en;
    logic             periodic;
    logic [CNT_W-3:0] initval;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             fire;

    assign active = en && tick;
    assign fire   = active && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            initval  <= '0;
            cnt      <= '1;
            pending  <= 1'b0;
        end else begin
            if (tcfg_we) begin
                en       <= tcfg_next[TCFG_EN];
                periodic <= tcfg_next[TCFG_PERIODIC];
                initval  <= tcfg_next[CNT_W-1:TCFG_INITVAL];
            end
            // An enabling config write reloads at once, without waiting for a tick.
            if (tcfg_we && tcfg_next[TCFG_EN]) begin
                cnt <= {tcfg_next[CNT_W-1:TCFG_INITVAL], 2'b00};
            end else if (active && (cnt != '1)) begin
                cnt <= (cnt == '0 && periodic) ? {initval, 2'b00} : cnt - CNT_W'(1);
            end
            if (fire) begin
                pending <= 1'b1;
            end else if (ticlr_we) begin
                pending <= 1'b0;
            end
        end
    end

    assign tcfg = 32'({initval, periodic, en});
    assign tval = 32'(cnt);

endmodule

// File: rtl/csr_timer_unit.sv
// CSR timer block: TID, prescaled timer channels and a free-running 64-bit stable counter.
// Reads are combinational from current state, so a same-cycle write is not visible yet.
module csr_timer_unit
    import csr_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          CNT_W      = 32,
    parameter int          PRESCALE   = 1,
    parameter logic [31:0] CORE_ID    = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csr_we,
    input  logic [13:0]           csr_wr_num,
    input  logic [31:0]           csr_wr_mask,
    input  logic [31:0]           csr_wr_value,
    input  logic [13:0]           csr_rd_num,
    output logic [31:0]           csr_rd_value,
    output logic                  csr_rd_hit,
    output logic [NUM_TIMERS-1:0] timer_int,
    output logic                  timer_int_any,
    output logic [63:0]           stable_cnt,
    output logic [31:0]           tid
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]                  prescaler;
    logic                             tick;
    logic [NUM_TIMERS-1:0][31:0]      tcfg;
    logic [NUM_TIMERS-1:0][31:0]      tval;
    logic [NUM_TIMERS-1:0]            tcfg_we;
    logic [NUM_TIMERS-1:0]            ticlr_we;

    assign tick = (prescaler == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            stable_cnt <= '0;
            tid        <= CORE_ID;
        end else begin
            prescaler  <= tick ? '0 : prescaler + PS_W'(1);
            stable_cnt <= stable_cnt + 64'd1;
            if (csr_we && csr_wr_num == CSR_TID) begin
                tid <= masked_merge(tid, csr_wr_value, csr_wr_mask);
            end
        end
    end

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : gen_chan
        // TICLR only acts when bit 0 is both selected by the mask and set in the data.
        assign tcfg_we[k]  = csr_we && (csr_wr_num == chan_addr(CSR_TCFG_BASE, k));
        assign ticlr_we[k] = csr_we && (csr_wr_num == chan_addr(CSR_TICLR_BASE, k))
                             && csr_wr_mask[TICLR_CLR] && csr_wr_value[TICLR_CLR];

        csr_timer_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .tcfg_we   (tcfg_we[k]),
            .ticlr_we  (ticlr_we[k]),
            .tcfg_next (CNT_W'(masked_merge(tcfg[k], csr_wr_value, csr_wr_mask))),
            .tcfg      (tcfg[k]),
            .tval      (tval[k]),
            .pending   (timer_int[k])
        );
    end

    assign timer_int_any = |timer_int;

    always_comb begin
        csr_rd_value = '0;
        csr_rd_hit   = 1'b0;
        if (csr_rd_num == CSR_TID) begin
            csr_rd_hit   = 1'b1;
            csr_rd_value = tid;
        end
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (csr_rd_num == chan_addr(CSR_TCFG_BASE, k)) begin
                csr_rd_hit   = 1'b1;
                csr_rd_value = tcfg[k];
            end else if (csr_rd_num == chan_addr(CSR_TVAL_BASE, k)) begin
                csr_rd_hit   = 1'b1;
                csr_rd_value = tval[k];
            end else if (csr_rd_num == chan_addr(CSR_RSV_BASE, k) ||
                         csr_rd_num == chan_addr(CSR_TICLR_BASE, k)) begin
                csr_rd_hit   = 1'b1;
            end
        end
    end

endmodule
